// File: rtl/sap_domain_pwr_ctrl.sv
// rtl/sap_domain_pwr_ctrl.sv - per-domain power sequencer (clock gate, isolation, retention, power switch)
module sap_domain_pwr_ctrl #(
    parameter int N_DOM    = 2,
    parameter int CG_DELAY = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_DOM-1:0] dom_on_i,
    input  logic [N_DOM-1:0] ret_i,
    input  logic [N_DOM-1:0] pwrgate_ack_ni,
    input  logic [N_DOM-1:0] err_clr_i,
    input  logic [N_DOM-1:0] irq_en_i,
    input  logic [N_DOM-1:0] irq_clr_i,
    output logic [N_DOM-1:0] clk_en_o,
    output logic [N_DOM-1:0] iso_o,
    output logic [N_DOM-1:0] pwrgate_no,
    output logic [N_DOM-1:0] set_retentive_no,
    output logic [N_DOM-1:0] busy_o,
    output logic [N_DOM-1:0] err_o,
    output logic             irq_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_ON, S_GATE, S_ISO, S_RET, S_PGREQ, S_OFF, S_PGREL, S_RESTORE, S_ERR
    } state_t;

    // {clk_en, iso, pwrgate_n, ret_n} as seen while sitting in state s
    function automatic logic [3:0] dom_outs(input state_t s, input logic ret, input logic ret_n_hold);
        logic [3:0] o;
        o = 4'b1011;
        case (s)
            S_ON:      o = 4'b1011;
            S_GATE:    o = 4'b0011;
            S_ISO:     o = 4'b0111;
            S_RET:     o = 4'b0110;
            S_PGREQ:   o = {3'b010, ~ret};
            S_OFF:     o = {3'b010, ~ret};
            S_PGREL:   o = {3'b011, ~ret};
            S_RESTORE: o = 4'b0011;
            S_ERR:     o = {3'b011, ret_n_hold};
            default:   o = 4'b1011;
        endcase
        return o;
    endfunction

    logic [N_DOM-1:0] pend_d;
    logic             irq_q;

    for (genvar d = 0; d < N_DOM; d++) begin : g_dom
        state_t        state_q, state_d;
        logic [TW-1:0] to_cnt_q;
        logic [7:0]    cg_cnt_q;
        logic          ret_q, ret_d;
        logic          pend_q, pend_set;
        logic          to_hit, cg_done;
        logic [3:0]    outs_q, outs_d;
        logic          busy_q, err_q;

        assign to_hit  = (to_cnt_q >= TW'(TIMEOUT - 1));
        assign cg_done = (cg_cnt_q >= 8'(CG_DELAY - 1));

        always_comb begin
            state_d = state_q;
            case (state_q)
                S_ON:      if (!dom_on_i[d]) state_d = S_GATE;
                S_GATE:    if (cg_done) state_d = S_ISO;
                S_ISO:     state_d = ret_q ? S_RET : S_PGREQ;
                S_RET:     state_d = S_PGREQ;
                S_PGREQ: begin
                    if (!pwrgate_ack_ni[d]) state_d = S_OFF;
                    else if (to_hit)        state_d = S_ERR;
                end
                S_OFF:     if (dom_on_i[d]) state_d = S_PGREL;
                S_PGREL: begin
                    if (pwrgate_ack_ni[d]) state_d = S_RESTORE;
                    else if (to_hit)       state_d = S_ERR;
                end
                S_RESTORE: state_d = S_ON;
                S_ERR:     if (err_clr_i[d]) state_d = S_PGREL;
                default:   state_d = S_ON;
            endcase
        end

        assign ret_d  = (state_q == S_ON && !dom_on_i[d]) ? ret_i[d] : ret_q;
        assign outs_d = dom_outs(state_d, ret_d, outs_q[0]);

        // Pending fires on arrival in OFF, ERR, or ON after a completed wake; set beats clear.
        assign pend_set = (state_d != state_q) &&
                          (state_d == S_OFF || state_d == S_ERR ||
                           (state_q == S_RESTORE && state_d == S_ON));
        assign pend_d[d] = pend_set | (pend_q & ~irq_clr_i[d]);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q  <= S_ON;
                to_cnt_q <= '0;
                cg_cnt_q <= '0;
                ret_q    <= 1'b0;
                pend_q   <= 1'b0;
                outs_q   <= 4'b1011;
                busy_q   <= 1'b0;
                err_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                ret_q   <= ret_d;
                pend_q  <= pend_d[d];
                outs_q  <= outs_d;
                busy_q  <= !(state_d == S_ON || state_d == S_OFF);
                err_q   <= (state_d == S_ERR);

                if ((state_d == S_PGREQ || state_d == S_PGREL) && state_d != state_q)
                    to_cnt_q <= '0;
                else if ((state_q == S_PGREQ || state_q == S_PGREL) && to_cnt_q != TW'(TIMEOUT))
                    to_cnt_q <= to_cnt_q + 1'b1;

                if (state_d == S_GATE && state_q != S_GATE)
                    cg_cnt_q <= '0;
                else if (state_q == S_GATE && cg_cnt_q != 8'hff)
                    cg_cnt_q <= cg_cnt_q + 1'b1;
            end
        end

        assign clk_en_o[d]         = outs_q[3];
        assign iso_o[d]            = outs_q[2];
        assign pwrgate_no[d]       = outs_q[1];
        assign set_retentive_no[d] = outs_q[0];
        assign busy_o[d]           = busy_q;
        assign err_o[d]            = err_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) irq_q <= 1'b0;
        else         irq_q <= |(pend_d & irq_en_i);
    end

    assign irq_o = irq_q;

endmodule

// File: tb/tb_sap_domain_pwr_ctrl.sv
// tb/tb_sap_domain_pwr_ctrl.sv - directed bench for sap_domain_pwr_ctrl
module tb_sap_domain_pwr_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [1:0] dom_on_i, ret_i, pwrgate_ack_ni, err_clr_i, irq_en_i, irq_clr_i;
    logic [1:0] clk_en_o, iso_o, pwrgate_no, set_retentive_no, busy_o, err_o;
    logic       irq_o;

    int n_chk = 0;
    int n_err = 0;

    sap_domain_pwr_ctrl #(.N_DOM(2), .CG_DELAY(2), .TIMEOUT(64)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .dom_on_i(dom_on_i), .ret_i(ret_i), .pwrgate_ack_ni(pwrgate_ack_ni),
        .err_clr_i(err_clr_i), .irq_en_i(irq_en_i), .irq_clr_i(irq_clr_i),
        .clk_en_o(clk_en_o), .iso_o(iso_o), .pwrgate_no(pwrgate_no),
        .set_retentive_no(set_retentive_no), .busy_o(busy_o), .err_o(err_o),
        .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] ce, input logic [1:0] iso,
                           input logic [1:0] pg, input logic [1:0] rn, input logic [1:0] bsy,
                           input logic [1:0] er, input logic irq);
        chk({tag, ".clk_en"}, 32'(clk_en_o), 32'(ce));
        chk({tag, ".iso"}, 32'(iso_o), 32'(iso));
        chk({tag, ".pwrgate_n"}, 32'(pwrgate_no), 32'(pg));
        chk({tag, ".ret_n"}, 32'(set_retentive_no), 32'(rn));
        chk({tag, ".busy"}, 32'(busy_o), 32'(bsy));
        chk({tag, ".err"}, 32'(err_o), 32'(er));
        chk({tag, ".irq"}, 32'(irq_o), 32'(irq));
    endtask

    task automatic clear_irq();
        irq_clr_i = 2'b11;
        tick();
        irq_clr_i = 2'b00;
    endtask

    initial begin
        rst_ni = 1'b0;
        dom_on_i = 2'b11; ret_i = 2'b00; pwrgate_ack_ni = 2'b11;
        err_clr_i = 2'b00; irq_en_i = 2'b01; irq_clr_i = 2'b00;
        tick(); tick();
        chk_all("reset", 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0);
        rst_ni = 1'b1;
        tick(); tick();
        chk_all("idle_on", 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0);

        // Domain 0 down without retention, ack three cycles into PGREQ, clr collides with set
        dom_on_i = 2'b10;
        tick(); chk_all("a_gate1", 2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b00, 1'b0);
        tick(); chk_all("a_gate2", 2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b00, 1'b0);
        tick(); chk_all("a_iso", 2'b10, 2'b01, 2'b11, 2'b11, 2'b01, 2'b00, 1'b0);
        tick(); chk_all("a_pgreq", 2'b10, 2'b01, 2'b10, 2'b11, 2'b01, 2'b00, 1'b0);
        tick(); tick();
        chk_all("a_pgreq3", 2'b10, 2'b01, 2'b10, 2'b11, 2'b01, 2'b00, 1'b0);
        pwrgate_ack_ni = 2'b10; irq_clr_i = 2'b01;
        tick(); chk_all("a_off_setwins", 2'b10, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 1'b1);
        irq_clr_i = 2'b00;
        tick(); chk("a_pend_held", 32'(irq_o), 32'd1);
        irq_clr_i = 2'b01;
        tick(); chk("a_irq_clr", 32'(irq_o), 32'd0);
        irq_clr_i = 2'b00;

        // Domain 0 wake
        dom_on_i = 2'b11;
        tick(); chk_all("a_pgrel", 2'b10, 2'b01, 2'b11, 2'b11, 2'b01, 2'b00, 1'b0);
        pwrgate_ack_ni = 2'b11;
        tick(); chk_all("a_restore", 2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b00, 1'b0);
        tick(); chk_all("a_on", 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1);
        clear_irq();

        // Domain 1 retention round trip; ret_i dropped after being latched
        ret_i = 2'b10; dom_on_i = 2'b01;
        tick(); chk_all("b_gate1", 2'b01, 2'b00, 2'b11, 2'b11, 2'b10, 2'b00, 1'b0);
        ret_i = 2'b00;
        tick(); chk_all("b_gate2", 2'b01, 2'b00, 2'b11, 2'b11, 2'b10, 2'b00, 1'b0);
        tick(); chk_all("b_iso", 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b00, 1'b0);
        tick(); chk_all("b_ret", 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b00, 1'b0);
        tick(); chk_all("b_pgreq", 2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b00, 1'b0);
        pwrgate_ack_ni = 2'b01;
        tick(); chk_all("b_off", 2'b01, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
        dom_on_i = 2'b11;
        tick(); chk_all("b_pgrel", 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b00, 1'b0);
        pwrgate_ack_ni = 2'b11;
        tick(); chk_all("b_restore", 2'b01, 2'b00, 2'b11, 2'b11, 2'b10, 2'b00, 1'b0);
        tick(); chk_all("b_on", 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0);
        clear_irq();

        // Target flips back during GATE: finish down, then wake on the next edge
        dom_on_i = 2'b10;
        tick(); chk_all("c_gate1", 2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b00, 1'b0);
        dom_on_i = 2'b11;
        tick(); tick();
        chk_all("c_iso", 2'b10, 2'b01, 2'b11, 2'b11, 2'b01, 2'b00, 1'b0);
        tick(); chk_all("c_pgreq", 2'b10, 2'b01, 2'b10, 2'b11, 2'b01, 2'b00, 1'b0);
        pwrgate_ack_ni = 2'b10;
        tick(); chk_all("c_off", 2'b10, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 1'b1);
        tick(); chk_all("c_pgrel", 2'b10, 2'b01, 2'b11, 2'b11, 2'b01, 2'b00, 1'b1);
        pwrgate_ack_ni = 2'b11;
        tick(); tick();
        chk_all("c_on", 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1);
        clear_irq();

        // err_clr outside ERR has no effect
        err_clr_i = 2'b01;
        tick();
        err_clr_i = 2'b00;
        chk_all("d_errclr_on", 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0);

        // Ack withheld: ERR after 64 PGREQ cycles, then recover via err_clr
        dom_on_i = 2'b10;
        tick(); tick(); tick(); tick();
        chk_all("e_pgreq", 2'b10, 2'b01, 2'b10, 2'b11, 2'b01, 2'b00, 1'b0);
        for (int i = 0; i < 63; i++) tick();
        chk_all("e_pgreq64", 2'b10, 2'b01, 2'b10, 2'b11, 2'b01, 2'b00, 1'b0);
        tick(); chk_all("e_err", 2'b10, 2'b01, 2'b11, 2'b11, 2'b01, 2'b01, 1'b1);
        tick(); chk_all("e_err_hold", 2'b10, 2'b01, 2'b11, 2'b11, 2'b01, 2'b01, 1'b1);
        err_clr_i = 2'b01; dom_on_i = 2'b11;
        tick(); chk_all("e_pgrel", 2'b10, 2'b01, 2'b11, 2'b11, 2'b01, 2'b00, 1'b1);
        err_clr_i = 2'b00;
        tick(); chk_all("e_restore", 2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b00, 1'b1);
        tick(); chk_all("e_on", 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1);
        clear_irq();

        // Asynchronous reset while in PGREQ
        dom_on_i = 2'b10;
        tick(); tick(); tick(); tick();
        chk_all("f_pgreq", 2'b10, 2'b01, 2'b10, 2'b11, 2'b01, 2'b00, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_all("f_async_rst", 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0);
        dom_on_i = 2'b11;
        tick();
        rst_ni = 1'b1;
        tick(); tick();
        chk_all("f_post_rst", 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0);
        dom_on_i = 2'b10;
        tick(); chk_all("f_leave_on", 2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
